// File: rtl/dct_rr_scheduler.sv
// rtl/dct_rr_scheduler.sv - round-robin sharing of one 8x8 DCT core among NREQ block requesters
module dct_rr_scheduler #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 32,
    parameter int CNTW    = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            core_start,
    input  logic            core_done,
    output logic            core_abort,
    output logic            out_valid,
    output logic [IDW-1:0]  out_id,
    input  logic            out_ready,
    output logic            busy,
    output logic            timeout_err,
    input  logic            err_clr,
    output logic [CNTW-1:0] blk_count
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_START   = 2'd1;
    localparam logic [1:0] S_BUSY    = 2'd2;
    localparam logic [1:0] S_DELIVER = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]  gnt_id_q, gnt_id_d;
    logic            core_start_q, core_start_d;
    logic            core_abort_q, core_abort_d;
    logic            out_valid_q, out_valid_d;
    logic [IDW-1:0]  out_id_q, out_id_d;
    logic            busy_q, busy_d;
    logic            timeout_err_q, timeout_err_d;
    logic [CNTW-1:0] blk_count_q, blk_count_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [WDW-1:0]  wdog_q, wdog_d;

    logic            pick_valid;
    logic [IDW-1:0]  pick_idx;
    logic [IDW-1:0]  cand_idx;
    logic            wdog_expired;

    // Walk downward in distance so the nearest requester after rr_ptr is the last writer.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand_idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        gnt_id_d      = gnt_id_q;
        core_start_d  = 1'b0;
        core_abort_d  = 1'b0;
        out_valid_d   = out_valid_q;
        out_id_d      = out_id_q;
        blk_count_d   = blk_count_q;
        rr_ptr_d      = rr_ptr_q;
        wdog_d        = wdog_q;
        wdog_expired  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d      = S_START;
                    gnt_d        = NREQ'(1) << pick_idx;
                    gnt_id_d     = pick_idx;
                    core_start_d = 1'b1;
                    rr_ptr_d     = pick_idx;
                end
            end
            S_START: begin
                state_d = S_BUSY;
                wdog_d  = '0;
            end
            S_BUSY: begin
                wdog_d = wdog_q + WDW'(1);
                if (core_done) begin
                    state_d     = S_DELIVER;
                    out_valid_d = 1'b1;
                    out_id_d    = gnt_id_q;
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    // rr_ptr stays on the aborted requester so it drops to lowest priority.
                    state_d      = S_IDLE;
                    gnt_d        = '0;
                    core_abort_d = 1'b1;
                    wdog_expired = 1'b1;
                end
            end
            default: begin
                if (out_valid_q && out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    gnt_d       = '0;
                    blk_count_d = blk_count_q + CNTW'(1);
                end
            end
        endcase

        if (wdog_expired) begin
            timeout_err_d = 1'b1;
        end else if (err_clr) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            gnt_q         <= '0;
            gnt_id_q      <= '0;
            core_start_q  <= 1'b0;
            core_abort_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_id_q      <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            blk_count_q   <= '0;
            rr_ptr_q      <= IDW'(NREQ - 1);
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            gnt_id_q      <= gnt_id_d;
            core_start_q  <= core_start_d;
            core_abort_q  <= core_abort_d;
            out_valid_q   <= out_valid_d;
            out_id_q      <= out_id_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            blk_count_q   <= blk_count_d;
            rr_ptr_q      <= rr_ptr_d;
            wdog_q        <= wdog_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_id      = gnt_id_q;
    assign core_start  = core_start_q;
    assign core_abort  = core_abort_q;
    assign out_valid   = out_valid_q;
    assign out_id      = out_id_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign blk_count   = blk_count_q;

endmodule

// File: tb/tb_dct_rr_scheduler.sv
// tb/tb_dct_rr_scheduler.sv - randomized transaction-level bench for dct_rr_scheduler
module tb_dct_rr_scheduler;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 32;
    localparam int CNTW    = 16;

    logic            clock = 1'b0;
    logic            reset;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            core_start;
    logic            core_done;
    logic            core_abort;
    logic            out_valid;
    logic [IDW-1:0]  out_id;
    logic            out_ready;
    logic            busy;
    logic            timeout_err;
    logic            err_clr;
    logic [CNTW-1:0] blk_count;

    dct_rr_scheduler #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
        .clock(clock), .reset(reset), .req(req), .gnt(gnt), .gnt_id(gnt_id),
        .core_start(core_start), .core_done(core_done), .core_abort(core_abort),
        .out_valid(out_valid), .out_id(out_id), .out_ready(out_ready), .busy(busy),
        .timeout_err(timeout_err), .err_clr(err_clr), .blk_count(blk_count)
    );

    always #5 clock = ~clock;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_ptr;
    int   exp_cnt;
    logic exp_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last_ptr + k) % NREQ]) return (last_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // d = cycle after the start cycle in which done pulses (0 = never); bp = cycles of out_ready low
    task automatic service(input logic [NREQ-1:0] r, input int d, input int bp, input logic clr_hold);
        int g;
        int limit;
        logic [31:0] exp_gnt;
        g = pick(r);
        exp_gnt = 32'(1) << g;
        req = r;
        @(negedge clock);
        check("grant", 32'(gnt), exp_gnt);
        check("grant_id", 32'(gnt_id), 32'(g));
        check("start_on", 32'(core_start), 32'd1);
        check("busy_on", 32'(busy), 32'd1);
        check("err_at_grant", 32'(timeout_err), 32'(exp_err));
        last_ptr = g;
        req = NREQ'($urandom);
        core_done = 1'b1;
        err_clr = clr_hold;
        limit = (d > 0) ? d : TIMEOUT;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clock);
            core_done = 1'b0;
            if (c == 1) check("start_once", 32'(core_start), 32'd0);
            check("no_abort", 32'(core_abort), 32'd0);
            check("no_valid", 32'(out_valid), 32'd0);
            if (c == d) core_done = 1'b1;
        end
        @(negedge clock);
        core_done = 1'b0;
        if (clr_hold) exp_err = 1'b0;
        if (d > 0) begin
            err_clr = 1'b0;
            check("valid_on", 32'(out_valid), 32'd1);
            check("out_id", 32'(out_id), 32'(g));
            check("abort_off", 32'(core_abort), 32'd0);
            check("err_after_done", 32'(timeout_err), 32'(exp_err));
            for (int b = 0; b < bp; b++) begin
                out_ready = 1'b0;
                core_done = 1'($urandom);
                @(negedge clock);
                check("bp_valid", 32'(out_valid), 32'd1);
                check("bp_gnt", 32'(gnt), exp_gnt);
                check("bp_id", 32'(out_id), 32'(g));
                check("bp_nostart", 32'(core_start), 32'd0);
            end
            core_done = 1'b0;
            out_ready = 1'b1;
            @(negedge clock);
            req = '0;
            out_ready = 1'b0;
            exp_cnt = (exp_cnt + 1) % (1 << CNTW);
            check("accept_valid", 32'(out_valid), 32'd0);
            check("accept_gnt", 32'(gnt), 32'd0);
            check("accept_busy", 32'(busy), 32'd0);
            check("blk_count", 32'(blk_count), 32'(exp_cnt));
        end else begin
            req = '0;
            err_clr = 1'b0;
            exp_err = 1'b1;
            check("abort_pulse", 32'(core_abort), 32'd1);
            check("abort_err", 32'(timeout_err), 32'd1);
            check("abort_gnt", 32'(gnt), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_count", 32'(blk_count), 32'(exp_cnt));
            @(negedge clock);
            check("abort_once", 32'(core_abort), 32'd0);
        end
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0;
        exp_err = 1'b0;
        check("err_clr", 32'(timeout_err), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_gnt_id"}, 32'(gnt_id), 32'd0);
        check({tag, "_start"}, 32'(core_start), 32'd0);
        check({tag, "_abort"}, 32'(core_abort), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_id"}, 32'(out_id), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(timeout_err), 32'd0);
        check({tag, "_count"}, 32'(blk_count), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req = '0; core_done = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        last_ptr = NREQ - 1; exp_cnt = 0; exp_err = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_vals("rst");
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 8; i++) service(4'hF, 18, 0, 1'b0);
        service(4'h1, 18, 0, 1'b0);
        service(4'h2, 18, 20, 1'b0);
        service(4'h2, 0, 0, 1'b0);
        service(4'hF, 18, 0, 1'b0);
        clear_err();
        service(4'h4, TIMEOUT, 0, 1'b0);
        service(4'h8, 0, 0, 1'b1);
        clear_err();

        req = 4'b0100;
        @(negedge clock);
        check("pre_rst_gnt", 32'(gnt), 32'h4);
        req = '0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_reset_vals("midrst");
        last_ptr = NREQ - 1; exp_cnt = 0; exp_err = 1'b0;
        core_done = 1'b1;
        @(negedge clock);
        core_done = 1'b0;
        check("spurious_valid", 32'(out_valid), 32'd0);
        check("spurious_busy", 32'(busy), 32'd0);
        service(4'hF, 18, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [NREQ-1:0] r;
            int d;
            r = NREQ'($urandom_range(1, 15));
            d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TIMEOUT);
            service(r, d, $urandom_range(0, 4), 1'($urandom));
            if (exp_err && ($urandom_range(0, 1) == 1)) clear_err();
            if ($urandom_range(0, 2) == 0) @(negedge clock);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
